// File: rtl/fp_sched_pkg.sv
// Shared types for the fp_add_sub request scheduler.
// Tag ids are sized for the largest supported requester count.
package fp_sched_pkg;
  localparam int FP_SIGN_BIT = 31;
  localparam int MAX_REQ = 8;
  localparam int ID_W = $clog2(MAX_REQ);

  typedef logic [31:0] fp32_t;
  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans req starting at ptr.
// Returns one-hot grant, encoded winner and any_grant.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] winner,
  output logic         any_grant
);

  always_comb begin
    int idx;
    idx = 0;
    grant = '0;
    winner = '0;
    any_grant = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!any_grant && req[idx]) begin
        any_grant = 1'b1;
        grant[idx] = 1'b1;
        winner = W'(idx);
      end
    end
  end

endmodule

// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler sharing one fp_add_sub unit among requesters.
// Owner ids ride a tag pipe aligned with the unit latency.
module fp_addsub_sched
  import fp_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int UNIT_LAT = 0,
  localparam int RW = $clog2(NUM_REQ),
  localparam int CW = $clog2(UNIT_LAT + 3)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0][31:0] req_a,
  input  logic [NUM_REQ-1:0][31:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output fp32_t                    rsp_data,
  output fp32_t                    num1,
  output fp32_t                    num2,
  input  fp32_t                    S,
  output logic                     busy,
  output logic [CW-1:0]            inflight
);

  logic [RW-1:0]      rr_ptr;
  logic [RW-1:0]      win;
  logic [RW-1:0]      next_ptr;
  logic [NUM_REQ-1:0] grant;
  logic               any;
  logic               accept;
  fp32_t              a_w;
  fp32_t              b_w;
  logic               sub_w;
  tag_t               tags [UNIT_LAT+1];
  tag_t               last;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .winner   (win),
    .any_grant(any)
  );

  assign req_ready = rst ? '0 : grant;
  assign accept = any & ~rst;
  assign a_w = req_a[win];
  assign b_w = req_b[win];
  assign sub_w = req_sub[win];
  assign last = tags[UNIT_LAT];
  assign busy = (inflight != '0);
  assign next_ptr = (win == RW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      num1 <= '0;
      num2 <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      inflight <= '0;
      for (int k = 0; k <= UNIT_LAT; k++) begin
        tags[k] <= '0;
      end
    end else begin
      if (accept) begin
        rr_ptr <= next_ptr;
        num1 <= a_w;
        num2 <= {b_w[FP_SIGN_BIT] ^ sub_w, b_w[FP_SIGN_BIT-1:0]};
      end
      tags[0].valid <= accept;
      tags[0].id <= req_id_t'(win);
      for (int k = 1; k <= UNIT_LAT; k++) begin
        tags[k] <= tags[k-1];
      end
      if (last.valid) begin
        rsp_valid <= NUM_REQ'(1) << last.id;
        rsp_data <= S;
      end else begin
        rsp_valid <= '0;
      end
      // count drops on the cycle the pulse is visible
      unique case ({accept, |rsp_valid})
        2'b10: inflight <= inflight + CW'(1);
        2'b01: inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
